// File: rtl/aes_block_sequencer_pkg.sv
// Shared types and constants for the AES block sequencer: FSM state encoding,
// block geometry, key-size codes and the block-count helper.
package aes_block_sequencer_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int BYTES_PER_BLOCK = 16;

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    STARTING          = 3'd1,
    REQUEST_DATA      = 3'd2,
    WORKING           = 3'd3,
    SEND_DATA         = 3'd4,
    MEMORY_WRITE_WAIT = 3'd5,
    FINISHED          = 3'd6
  } aes_seq_state_t;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2
  } aes_key_mode_t;

  // Widened by one bit so a length of 0xFFFFFFFF rounds up without wrapping.
  function automatic logic [28:0] block_count(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'd15;
    return sum[32:4];
  endfunction

endpackage

// File: rtl/aes_block_sequencer_if.sv
// Stream and AES-core signals of the block sequencer, grouped as one bundle.
// master = sequencer side, slave = streamers/core side.
interface aes_block_sequencer_if;

  // Valid/ready: a transfer happens on every clock edge where valid and ready
  // are both high; a source keeps valid and data stable until that edge.
  logic         in_valid_i;
  logic [31:0]  in_data_i;
  logic         in_ready_o;
  logic         core_start_o;
  logic [127:0] core_block_o;
  logic [1:0]   core_key_mode_o;
  logic         core_done_i;
  logic [127:0] core_result_i;
  logic         out_valid_o;
  logic [31:0]  out_data_o;
  logic         out_ready_i;

  modport master (
    input  in_valid_i, in_data_i, core_done_i, core_result_i, out_ready_i,
    output in_ready_o, core_start_o, core_block_o, core_key_mode_o,
           out_valid_o, out_data_o
  );

  modport slave (
    output in_valid_i, in_data_i, core_done_i, core_result_i, out_ready_i,
    input  in_ready_o, core_start_o, core_block_o, core_key_mode_o,
           out_valid_o, out_data_o
  );

endinterface

// File: rtl/aes_block_packer.sv
// Four-word pack/unpack register: words fill the block MSW-first, a whole core
// result can be loaded, and the same word index walks it back out MSW-first.
module aes_block_packer
  import aes_block_sequencer_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               word_load_en_i,
  input  logic               block_load_en_i,
  input  logic               shift_en_i,
  input  logic [WORD_W-1:0]  word_i,
  input  logic [BLOCK_W-1:0] block_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic [WORD_W-1:0]  word_o,
  output logic               last_o
);

  logic [BLOCK_W-1:0] block_q;
  logic [1:0]         idx_q;

  // Word k sits at bit offset 32*(3-k); ~idx_q is exactly 3-k.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      block_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      block_q <= '0;
      idx_q   <= '0;
    end else if (block_load_en_i) begin
      block_q <= block_i;
      idx_q   <= '0;
    end else if (word_load_en_i) begin
      block_q[{~idx_q, 5'd0} +: WORD_W] <= word_i;
      idx_q <= idx_q + 2'd1;
    end else if (shift_en_i) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  assign block_o = block_q;
  assign word_o  = block_q[{~idx_q, 5'd0} +: WORD_W];
  assign last_o  = (idx_q == 2'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/aes_block_sequencer.sv
// Control FSM driving one AES core over a byte buffer, one 128-bit block at a time.
// Optional WORKING-cycle counter: define AES_BLOCK_SEQUENCER_PERF_CNT_EN.
module aes_block_sequencer
  import aes_block_sequencer_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [31:0]           data_byte_length_i,
  input  logic [1:0]            key_mode_i,
  output logic                  streamers_start_o,
  aes_block_sequencer_if.master bus,
  input  logic                  sink_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           perf_cycles_o,
  output aes_seq_state_t        state_o
);

  aes_seq_state_t state_q, state_d;
  logic [28:0]    blk_left_q;
  logic [1:0]     key_mode_q;
  logic           launched_q;
  logic           word_load_en, block_load_en, shift_en, last_word;
  logic           in_hs, out_hs, job_accept;

  assign in_hs      = (state_q == REQUEST_DATA) && bus.in_valid_i;
  assign out_hs     = (state_q == SEND_DATA) && bus.out_ready_i;
  assign job_accept = (state_q == IDLE) && start_i;

  aes_block_packer #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W)) u_packer (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .word_load_en_i  (word_load_en),
    .block_load_en_i (block_load_en),
    .shift_en_i      (shift_en),
    .word_i          (bus.in_data_i),
    .block_i         (bus.core_result_i),
    .block_o         (bus.core_block_o),
    .word_o          (bus.out_data_o),
    .last_o          (last_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        state_q <= IDLE;
    else if (clear_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:              if (start_i) state_d = STARTING;
      STARTING:          state_d = (blk_left_q == '0) ? FINISHED : REQUEST_DATA;
      REQUEST_DATA:      if (in_hs && last_word) state_d = WORKING;
      WORKING:           if (bus.core_done_i) state_d = SEND_DATA;
      SEND_DATA:
        if (out_hs && last_word)
          state_d = (blk_left_q == 29'd1) ? MEMORY_WRITE_WAIT : REQUEST_DATA;
      MEMORY_WRITE_WAIT: if (sink_done_i) state_d = FINISHED;
      FINISHED:          state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    streamers_start_o = (state_q == STARTING);
    bus.in_ready_o    = (state_q == REQUEST_DATA);
    bus.core_start_o  = (state_q == WORKING) && !launched_q;
    bus.out_valid_o   = (state_q == SEND_DATA);
    busy_o            = (state_q != IDLE);
    done_o            = (state_q == FINISHED);
    word_load_en      = in_hs;
    block_load_en     = (state_q == WORKING) && bus.core_done_i;
    shift_en          = out_hs;
  end

  // launched_q is low on the first WORKING cycle because WORKING is always
  // entered from REQUEST_DATA.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_left_q <= '0;
      key_mode_q <= '0;
      launched_q <= 1'b0;
    end else if (clear_i) begin
      blk_left_q <= '0;
      key_mode_q <= '0;
      launched_q <= 1'b0;
    end else begin
      launched_q <= (state_q == WORKING);
      if (job_accept) begin
        blk_left_q <= block_count(data_byte_length_i);
        key_mode_q <= key_mode_i;
      end else if (out_hs && last_word) begin
        blk_left_q <= blk_left_q - 29'd1;
      end
    end
  end

  assign bus.core_key_mode_o = key_mode_q;
  assign state_o             = state_q;

`ifdef AES_BLOCK_SEQUENCER_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        perf_q <= '0;
    else if (clear_i || job_accept)                   perf_q <= '0;
    else if (state_q == WORKING && perf_q != '1)      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: doc/aes_block_sequencer.md
Name: aes_block_sequencer

Overview:
- Control FSM that sequences one AES engine over a byte buffer.
- Starts the input source and output sink streamers.
- Packs four 32-bit stream words into one 128-bit block, launches the core, unpacks the result back to four words, and repeats until all blocks are done.
- Sits between the HWPE register file/controller and the AES core plus streamers inside the engine wrapper.

Parameters:
- WORD_W, 32, stream word width in bits; fixed to 32, and only 32 is supported.
- BLOCK_W, 128, AES block width in bits; must equal 4*WORD_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous clear; same effect as reset
- start_i  in  1  job start pulse; ignored unless IDLE
- data_byte_length_i  in  32  job length in bytes; sampled on start
- key_mode_i  in  2  key size code; sampled on start
- streamers_start_o  out  1  one-cycle pulse to start the source and sink streamers
- in_valid_i  in  1  input stream valid
- in_data_i  in  32  input stream word
- in_ready_o  out  1  input stream ready
- core_start_o  out  1  one-cycle block launch to the AES core
- core_block_o  out  128  packed plaintext/ciphertext block
- core_key_mode_o  out  2  latched key mode
- core_done_i  in  1  core result valid (single-cycle)
- core_result_i  in  128  core output block
- out_valid_o  out  1  output stream valid
- out_data_o  out  32  output stream word
- out_ready_i  in  1  output stream ready
- sink_done_i  in  1  sink flag: all writes committed
- busy_o  out  1  high whenever not IDLE
- done_o  out  1  one-cycle job-complete event
- perf_cycles_o  out  32  see Optional Feature

Behaviour:
- Reset/clear values: all outputs 0; state = IDLE; internal counters and registers 0.
- Clock and reset: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset or clear mid-job aborts immediately; no done_o pulse is issued.
- Block count: nblk = ceil(len/16), computed as (len+15)>>4 using a 33-bit intermediate so len = 0xFFFFFFFF does not overflow.
- Partial last block: processed as a full block; the streamer zero-pads, and this block ignores the padding.
- IDLE -> STARTING: on start_i. Latch nblk and key_mode_i.
- STARTING:
  - streamers_start_o = 1 for exactly this cycle.
  - Next state is REQUEST_DATA, or FINISHED if nblk = 0.
- REQUEST_DATA:
  - in_ready_o = 1.
  - Each in_valid_i & in_ready_o handshake stores a word; word k (0..3) goes to block bits [127-32k -: 32].
  - After the 4th handshake -> WORKING.
  - in_ready_o drops in the cycle after the 4th handshake.
- WORKING:
  - core_start_o = 1 on the first cycle only.
  - core_block_o is stable for the whole state.
  - Wait for core_done_i, then capture core_result_i -> SEND_DATA.
  - A core_done_i arriving on the same cycle as core_start_o is accepted.
- SEND_DATA:
  - out_valid_o = 1; out_data_o = result word j, taking bits [127-32j -: 32] for j = 0..3.
  - j advances only on out_valid_o & out_ready_i.
  - out_data_o is held stable while out_ready_i = 0.
  - After the 4th handshake, decrement the remaining block count. If blocks remain -> REQUEST_DATA, else -> MEMORY_WRITE_WAIT.
- MEMORY_WRITE_WAIT: wait for sink_done_i -> FINISHED. sink_done_i is sampled only in this state.
- FINISHED: done_o = 1 for one cycle -> IDLE.
- start_i is ignored outside IDLE, including on the done_o cycle.
- Minimum latency per block: 4 input cycles + 1 launch cycle + core latency + 4 output cycles.
- No overlap between fetch of block n+1 and processing of block n.

Optional Feature:
- Macro: AES_BLOCK_SEQUENCER_PERF_CNT_EN.
- Defined:
  - perf_cycles_o counts cycles spent in WORKING since the last start; it saturates at 0xFFFFFFFF.
  - The counter clears on start_i accepted in IDLE, and on reset/clear.
  - The value is held after done_o.
- Undefined: perf_cycles_o is tied to 0 and no counter flops are inferred.

Decomposition:
- aes_package holds:
  - enum aes_seq_state_t with states IDLE, STARTING, REQUEST_DATA, WORKING, SEND_DATA, MEMORY_WRITE_WAIT, FINISHED;
  - constants WORDS_PER_BLOCK = 4 and BYTES_PER_BLOCK = 16;
  - key mode codes (0 = 128-bit, 1 = 192-bit, 2 = 256-bit).
- One sub-module: aes_block_packer. It is a 4-word pack/unpack register with a 2-bit word index, and has load/shift enables driven by the FSM.

Test Plan:
- len = 16, key_mode = 2, input words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, core model returns the bitwise inverse:
  - core_block_o = 0x00112233_44556677_8899AABB_CCDDEEFF;
  - output words are 0xFFEEDDCC, 0xBBAA9988, 0x77665544, 0x33221100;
  - one streamers_start_o pulse and one done_o pulse.
- len = 0 -> STARTING, FINISHED, IDLE: done_o two cycles after start_i, no core_start_o, in_ready_o never asserted.
- len = 33 -> 3 blocks: exactly 3 core_start_o pulses, 12 input and 12 output handshakes, done_o only after sink_done_i.
- Random in_valid_i / out_ready_i stalls (50% duty) with len = 48 -> output sequence identical to the no-stall run; out_data_o stable across every stall cycle.
- rst_i asserted while in WORKING, then start_i with len = 16 -> all outputs 0 immediately on reset, no done_o; the new job completes correctly.
- With AES_BLOCK_SEQUENCER_PERF_CNT_EN defined, core latency 14 cycles, len = 32 -> perf_cycles_o = 30 at done_o (2 x 15 WORKING cycles); without the macro it reads 0.
